// File: rtl/uk101_bus_arbiter.sv
// UK101 system-bus arbiter: shares the external SRAM/ROM/UART bus between the
// 6502 CPU port and the video character-fetch port, one fixed-length access at a time.
module uk101_bus_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2,       // strobe cycles per access, 1..15
  parameter logic [15:0] VID_BASE    = 16'hD000
) (
  input  logic        cpu_clk,
  input  logic        rst,

  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,

  input  logic        vid_req,
  input  logic [10:0] vid_addr,
  output logic [7:0]  vid_rdata,
  output logic        vid_ack,

  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_rd,
  output logic        mem_we,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        last_gnt_q, last_gnt_d;  // 0 = CPU, 1 = video; also the port owning the current access
  logic        gnt_we_q, gnt_we_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic [7:0]  vid_rdata_q, vid_rdata_d;

  logic        grant_cpu;
  logic        grant_vid;

  // On a tie the port that did not win last time is served.
  assign grant_cpu = cpu_req && (!vid_req || last_gnt_q);
  assign grant_vid = vid_req && !grant_cpu;

  // NOTE: state uses non-blocking assignments so every register sees the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_gnt_q  <= 1'b1;
      gnt_we_q    <= 1'b0;
      cnt_q       <= 4'd0;
      mem_addr_q  <= 16'd0;
      mem_wdata_q <= 8'd0;
      cpu_rdata_q <= 8'd0;
      vid_rdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      gnt_we_q    <= gnt_we_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
    end
  end

  // NOTE: every signal gets a hold-value default first, so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    gnt_we_d    = gnt_we_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_cpu) begin
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          gnt_we_d    = cpu_we;
          last_gnt_d  = 1'b0;
          cnt_d       = CNT_LOAD;
          state_d     = ACCESS;
        end else if (grant_vid) begin
          mem_addr_d  = VID_BASE + {5'b0, vid_addr};
          mem_wdata_d = 8'd0;
          gnt_we_d    = 1'b0;
          last_gnt_d  = 1'b1;
          cnt_d       = CNT_LOAD;
          state_d     = ACCESS;
        end
      end

      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          // Read data is sampled on the final strobe edge, into the owner's register.
          if (!gnt_we_q) begin
            if (last_gnt_q) vid_rdata_d = mem_rdata;
            else            cpu_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      DONE:    state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // Strobes and acks decode straight from the state so reset drops them at once.
  always_comb begin
    mem_rd  = (state_q == ACCESS) && !gnt_we_q;
    mem_we  = (state_q == ACCESS) &&  gnt_we_q;
    cpu_ack = (state_q == DONE)   && !last_gnt_q;
    vid_ack = (state_q == DONE)   &&  last_gnt_q;
    busy    = (state_q != IDLE);
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign vid_rdata = vid_rdata_q;

endmodule

// File: tb/tb_uk101_bus_arbiter.sv
// Directed bench for uk101_bus_arbiter: a bus memory model answers reads and a
// scoreboard of expected accesses is checked on every strobe and acknowledge.
module tb_uk101_bus_arbiter;

  localparam int          WAIT  = 2;
  localparam logic [15:0] VBASE = 16'hD000;

  logic        cpu_clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_ack;
  logic        vid_req;
  logic [10:0] vid_addr;
  logic [7:0]  vid_rdata;
  logic        vid_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_rd, mem_we, busy;

  typedef struct {
    logic        vid;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } acc_t;

  acc_t       sb[$];
  int         ack_cycs[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         strobe_run = 0;
  int         ack_count = 0;
  int         last_ack_cyc = 0;
  logic [7:0] exp_cpu_rdata = 8'h00;
  logic [7:0] exp_vid_rdata = 8'h00;
  bit         auto_drop = 1'b1;

  uk101_bus_arbiter #(.WAIT_CYCLES(WAIT), .VID_BASE(VBASE)) dut (
    .cpu_clk(cpu_clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_rd(mem_rd), .mem_we(mem_we), .busy(busy)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Memory contents are a fixed function of the address.
  function automatic logic [7:0] bus_data(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hD8;
  endfunction

  assign mem_rdata = bus_data(mem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    acc_t e;
    if (mem_rd || mem_we) begin
      check("strobe_excl", 32'(mem_rd & mem_we), 0);
      check("strobe_sb", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb[0];
        check("mem_addr", 32'(mem_addr), 32'(e.addr));
        check("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
        check("mem_we", 32'(mem_we), 32'(e.we));
        check("mem_rd", 32'(mem_rd), 32'(!e.we));
      end
      strobe_run++;
    end
    if (!busy) check("idle_strobe", 32'({mem_rd, mem_we}), 0);
    if (cpu_ack || vid_ack) begin
      check("ack_excl", 32'(cpu_ack & vid_ack), 0);
      check("done_strobe", 32'({mem_rd, mem_we}), 0);
      check("done_busy", 32'(busy), 1);
      check("ack_sb", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("ack_port", 32'(vid_ack), 32'(e.vid));
        check("done_addr_hold", 32'(mem_addr), 32'(e.addr));
        check("strobe_len", 32'(strobe_run), 32'(WAIT));
        if (!e.we) begin
          if (e.vid) exp_vid_rdata = bus_data(e.addr);
          else       exp_cpu_rdata = bus_data(e.addr);
        end
        check("cpu_rdata", 32'(cpu_rdata), 32'(exp_cpu_rdata));
        check("vid_rdata", 32'(vid_rdata), 32'(exp_vid_rdata));
      end
      strobe_run = 0;
      ack_count++;
      last_ack_cyc = cyc;
      ack_cycs.push_back(cyc);
      if (auto_drop) begin
        if (cpu_ack) cpu_req = 1'b0;
        if (vid_ack) vid_req = 1'b0;
      end
    end
  endtask

  // Outputs are sampled 1 ns after each rising edge; inputs change there too.
  task automatic tick();
    @(posedge cpu_clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic wait_acks(input int n);
    int start = ack_count;
    int k = 0;
    while ((ack_count - start) < n && k < 40) begin
      tick();
      k++;
    end
    check("ack_wait", 32'(ack_count - start), 32'(n));
  endtask

  task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                            input string tag);
    int c0;
    sb.push_back('{1'b0, we, addr, wd});
    cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    c0 = cyc;
    wait_acks(1);
    check({tag, "_latency"}, 32'(last_ack_cyc - c0), 32'(WAIT + 1));
    tick();
    check({tag, "_idle"}, 32'(busy), 0);
  endtask

  task automatic vid_access(input logic [10:0] off, input string tag);
    int c0;
    sb.push_back('{1'b1, 1'b0, VBASE + {5'b0, off}, 8'h00});
    vid_addr = off; vid_req = 1'b1;
    c0 = cyc;
    wait_acks(1);
    check({tag, "_latency"}, 32'(last_ack_cyc - c0), 32'(WAIT + 1));
    tick();
    check({tag, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    int n0, c0, base;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
    vid_req = 1'b0; vid_addr = 11'h0;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_rd", 32'(mem_rd), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_cpu_ack", 32'(cpu_ack), 0);
    check("rst_vid_ack", 32'(vid_ack), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_wdata", 32'(mem_wdata), 0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 0);
    check("rst_vid_rdata", 32'(vid_rdata), 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // CPU read of A123
    cpu_access(1'b0, 16'hA123, 8'h00, "cpu_rd");
    check("cpu_rdata_a123", 32'(cpu_rdata), 32'h5A);

    // CPU write leaves read data alone
    cpu_access(1'b1, 16'h0200, 8'h3C, "cpu_wr");
    check("wr_keeps_rdata", 32'(cpu_rdata), 32'h5A);

    // Video fetch at the top of the 2K window
    vid_access(11'h7FF, "vid");
    check("vid_rdata_d7ff", 32'(vid_rdata), 32'hF0);
    check("vid_keeps_cpu", 32'(cpu_rdata), 32'h5A);

    // Request held one cycle past ack gives a second access
    auto_drop = 1'b0;
    n0 = ack_count;
    sb.push_back('{1'b0, 1'b0, 16'h0345, 8'h11});
    sb.push_back('{1'b0, 1'b0, 16'h0345, 8'h11});
    cpu_we = 1'b0; cpu_addr = 16'h0345; cpu_wdata = 8'h11; cpu_req = 1'b1;
    wait_acks(1);
    tick();
    tick();
    cpu_req = 1'b0;
    wait_acks(1);
    check("rerequest_spacing", 32'(ack_cycs[ack_cycs.size()-1] - ack_cycs[ack_cycs.size()-2]),
          32'(WAIT + 2));
    for (int i = 0; i < 6; i++) tick();
    check("rerequest_two_acks", 32'(ack_count - n0), 2);
    auto_drop = 1'b1;

    // Reset during the second strobe cycle aborts the access
    sb.push_back('{1'b0, 1'b0, 16'h4567, 8'h00});
    cpu_we = 1'b0; cpu_addr = 16'h4567; cpu_wdata = 8'h00; cpu_req = 1'b1;
    tick();
    tick();
    check("pre_rst_rd", 32'(mem_rd), 1);
    rst = 1'b1;
    #1;
    check("abort_rd", 32'(mem_rd), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_ack", 32'({cpu_ack, vid_ack}), 0);
    check("abort_rdata", 32'(cpu_rdata), 0);
    sb.delete();
    strobe_run = 0;
    exp_cpu_rdata = 8'h00;
    exp_vid_rdata = 8'h00;
    cpu_req = 1'b0;
    n0 = ack_count;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    check("abort_no_ack", 32'(ack_count - n0), 0);
    cpu_access(1'b0, 16'h4567, 8'h00, "post_rst");
    check("post_rst_rdata", 32'(cpu_rdata), 32'hFA);

    // Both ports requesting from reset: strict alternation starting with CPU
    rst = 1'b1;
    auto_drop = 1'b0;
    sb.delete();
    strobe_run = 0;
    exp_cpu_rdata = 8'h00;
    exp_vid_rdata = 8'h00;
    cpu_we = 1'b0; cpu_addr = 16'h1234; cpu_wdata = 8'h00; cpu_req = 1'b1;
    vid_addr = 11'h123; vid_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{1'b0, 1'b0, 16'h1234, 8'h00});
      sb.push_back('{1'b1, 1'b0, 16'hD123, 8'h00});
    end
    tick(); tick();
    rst = 1'b0;
    c0 = cyc;
    base = ack_cycs.size();
    n0 = ack_count;
    wait_acks(4);
    cpu_req = 1'b0;
    vid_req = 1'b0;
    if (ack_cycs.size() >= base + 4) begin
      check("contend_first", 32'(ack_cycs[base] - c0), 32'(WAIT + 1));
      for (int i = 1; i < 4; i++)
        check("contend_spacing", 32'(ack_cycs[base+i] - ack_cycs[base+i-1]), 32'(WAIT + 2));
    end
    for (int i = 0; i < 6; i++) tick();
    check("contend_total", 32'(ack_count - n0), 4);
    check("contend_sb_empty", 32'(sb.size()), 0);
    check("contend_vid_rdata", 32'(vid_rdata), 32'h2A);
    auto_drop = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
